uart_rx_fifo_ctrl: RTL

Read-side controller for the UART receive FIFO. It drains FIFO entries into a single-entry valid/ready output register for the bus or DMA consumer. It also sequences FIFO flushes, raises trigger-level and character-timeout interrupts, and keeps sticky overflow status. It sits between the RX FIFO and the register/bus interface.

---
 rtl/uart_rx_fifo_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// Read-side controller for the UART receive FIFO.
// Drains FIFO entries into a single-entry valid/ready output register,
// sequences FIFO flushes, and raises threshold, timeout and overflow status.
// Optional statistics counters are compiled in with UART_RX_FIFO_CTRL_STATS_EN.
module uart_rx_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TO_W       = 16,
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_empty,
  input  logic [CW-1:0]         fifo_data_count,
  input  logic                  fifo_overflow,
  output logic                  fifo_read_en,
  output logic                  fifo_clear,
  input  logic                  rx_char_strobe,
  input  logic                  rx_enable,
  input  logic                  flush_req,
  input  logic [CW-1:0]         trig_level,
  input  logic [TO_W-1:0]       timeout_limit,
  input  logic [2:0]            irq_mask,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2:0]            irq_status,
`ifdef UART_RX_FIFO_CTRL_STATS_EN
  output logic [15:0]           stat_rx_count,
  output logic [7:0]            stat_to_count,
`endif
  output logic                  irq
);

  typedef enum logic [1:0] {StIdle, StValid, StFlush} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  to_sticky_q, to_sticky_d;
  logic                  ovf_sticky_q, ovf_sticky_d;
  logic                  ovf_prev_q;
  logic                  thresh_q, thresh_d;
  logic                  irq_q;

  logic is_idle, is_valid, load, handshake, flush_eff;
  logic to_active, to_hit, ovf_rise;

  assign is_idle   = (state_q == StIdle);
  assign is_valid  = (state_q == StValid);
  // flush_req wins over both a new load and a pending handshake.
  assign load      = rx_enable & ~fifo_empty & (is_idle | (is_valid & m_ready)) & ~flush_req;
  assign handshake = is_valid & m_ready & ~flush_req;
  // A flush request arriving while already flushing has no effect.
  assign flush_eff = flush_req & (state_q != StFlush);

  assign fifo_read_en = load;
  assign fifo_clear   = (state_q == StFlush);
  assign m_valid      = is_valid;
  assign m_data       = m_data_q;

  // Next-state logic for the output register FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (flush_req) state_d = StFlush;
        else if (load) state_d = StValid;
      end
      StValid: begin
        if (flush_req)    state_d = StFlush;
        else if (load)    state_d = StValid;
        else if (m_ready) state_d = StIdle;
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Idle-timeout counter: runs while data is pending, saturates at all-ones.
  assign to_active = ~fifo_empty | is_valid;
  assign to_hit    = (timeout_limit != '0) && (to_cnt_q == timeout_limit);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (flush_eff || rx_char_strobe || handshake || !to_active) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != {TO_W{1'b1}}) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Sticky status next-state; a set in the same cycle as a clear wins.
  assign ovf_rise = fifo_overflow & ~ovf_prev_q;

  always_comb begin
    to_sticky_d = to_sticky_q;
    if (to_hit)                      to_sticky_d = 1'b1;
    else if (handshake || flush_eff) to_sticky_d = 1'b0;

    ovf_sticky_d = ovf_sticky_q;
    if (ovf_rise)                  ovf_sticky_d = 1'b1;
    else if (ovf_clr || flush_eff) ovf_sticky_d = 1'b0;

    thresh_d = (trig_level != '0) && (fifo_data_count >= trig_level);
  end

  assign irq_status = {ovf_sticky_q, to_sticky_q, thresh_q};
  assign irq        = irq_q;

  // State, data and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      m_data_q     <= '0;
      to_cnt_q     <= '0;
      to_sticky_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      ovf_prev_q   <= 1'b0;
      thresh_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (load) m_data_q <= fifo_read_data;
      to_cnt_q     <= to_cnt_d;
      to_sticky_q  <= to_sticky_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_prev_q   <= fifo_overflow;
      thresh_q     <= thresh_d;
      irq_q        <= |(irq_status & irq_mask);
    end
  end

`ifdef UART_RX_FIFO_CTRL_STATS_EN
  logic [15:0] stat_rx_q;
  logic [7:0]  stat_to_q;

  // Statistics counters; only rst_n clears them, a flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rx_q <= '0;
      stat_to_q <= '0;
    end else begin
      if (handshake) stat_rx_q <= stat_rx_q + 16'd1;
      if (to_sticky_d && !to_sticky_q && (stat_to_q != 8'hff)) stat_to_q <= stat_to_q + 8'd1;
    end
  end

  assign stat_rx_count = stat_rx_q;
  assign stat_to_count = stat_to_q;
`endif

endmodule
